jk_bank_ctrl: RTL and testbench

Command-driven sequencer for a bank of WIDTH JK flip-flops (FFJK instances, one per bit), driving every J/K pair and observing the Q outputs.
- Single-cycle operations: set, clear, toggle, load.
- Multi-cycle operations: binary up and down counting, built by generating toggle enables from Q feedback.
- LOAD read-back is checked and a mismatch is flagged.
- Sits between a host command source (valid/ready) and the FF bank; the bank shares clk_i/rst_i.

---
 rtl/jk_bank_ctrl.sv | 153 +++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of WIDTH JK flip-flops.
// Accepts one host command at a time. The command either drives J/K for a
// single cycle (SET/CLR/TOG/LOAD) or runs a binary up/down count built from
// toggle enables derived from the observed Q outputs. LOAD results are read
// back from the bank, and a mismatch raises a sticky error flag.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o is high only in IDLE. While the
// controller is busy, cmd_valid_i is ignored and the host must hold or
// re-present the command.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_len_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  // Operation codes
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_TOG  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_UP   = 3'b101;
  localparam logic [2:0] OP_DOWN = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] remain_q;
  logic             err_q;

  logic             accept;
  logic             load_mismatch;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_down;

  assign accept        = cmd_valid_i && (state == ST_IDLE);
  assign load_mismatch = (state == ST_CHECK) && (op_q == OP_LOAD) && (q_i != data_q);

  // Next-state selection: the command decode happens on the accept edge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_i)
            OP_SET, OP_CLR, OP_TOG, OP_LOAD: state_nxt = ST_DRIVE;
            OP_UP, OP_DOWN: begin
              if (cmd_len_i == '0) state_nxt = ST_CHECK;
              else                 state_nxt = ST_RUN;
            end
            default: state_nxt = ST_CHECK;  // NOP and reserved
          endcase
        end
      end
      ST_DRIVE: state_nxt = ST_CHECK;
      ST_RUN: begin
        if (remain_q == CNT_W'(1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation without a completion pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Latched command and remaining-step counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      data_q   <= '0;
      remain_q <= '0;
    end else if (accept) begin
      op_q     <= cmd_op_i;
      data_q   <= cmd_data_i;
      remain_q <= cmd_len_i;
    end else if (state == ST_RUN) begin
      remain_q <= remain_q - CNT_W'(1);
    end
  end

  // Sticky error: cleared on every accept, set by a reserved op or LOAD mismatch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              err_q <= 1'b0;
    else if (accept)        err_q <= (cmd_op_i == OP_RSV);
    else if (load_mismatch) err_q <= 1'b1;
  end

  // Ripple toggle enables for binary counting from the current Q value
  always_comb begin
    t_up      = '0;
    t_down    = '0;
    t_up[0]   = 1'b1;
    t_down[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i]   = t_up[i-1]   &  q_i[i-1];
      t_down[i] = t_down[i-1] & ~q_i[i-1];
    end
  end

  // J/K drive: only DRIVE and RUN touch the bank; every other state holds it
  always_comb begin
    j_o = '0;
    k_o = '0;
    if (state == ST_DRIVE) begin
      case (op_q)
        OP_SET:  begin j_o = data_q; k_o = '0;      end
        OP_CLR:  begin j_o = '0;     k_o = data_q;  end
        OP_TOG:  begin j_o = data_q; k_o = data_q;  end
        OP_LOAD: begin j_o = data_q; k_o = ~data_q; end
        default: begin j_o = '0;     k_o = '0;      end
      endcase
    end else if (state == ST_RUN) begin
      case (op_q)
        OP_UP:   begin j_o = t_up;   k_o = t_up;    end
        OP_DOWN: begin j_o = t_down; k_o = t_down;  end
        default: begin j_o = '0;     k_o = '0;      end
      endcase
    end
  end

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_CHECK);
  // A LOAD mismatch is visible during CHECK itself, then held by err_q
  assign err_o       = err_q | load_mismatch;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed testbench for jk_bank_ctrl with a behavioural JK flip-flop bank.
module tb_jk_bank_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op_i    = '0;
  logic [WIDTH-1:0] cmd_data_i  = '0;
  logic [CNT_W-1:0] cmd_len_i   = '0;
  logic [WIDTH-1:0] q_i;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  logic [WIDTH-1:0] bank_q;
  logic             force_zero = 1'b0;

  int checks = 0;
  int errors = 0;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_len_i   (cmd_len_i),
    .q_i         (q_i),
    .j_o         (j_o),
    .k_o         (k_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Behavioural JK flip-flop bank sharing clock and reset with the controller
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bank_q <= '0;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_o[i], k_o[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  assign q_i = force_zero ? '0 : bank_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a command and return just after its accept edge (E0)
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [CNT_W-1:0] len);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_data_i  = data;
    cmd_len_i   = len;
    step();
    cmd_valid_i = 1'b0;
  endtask

  // One single-cycle op: checks drive, result, done pulse and ready timing
  task automatic single_op(input string tag, input logic [2:0] op,
                           input logic [WIDTH-1:0] data,
                           input logic [WIDTH-1:0] exp_j, input logic [WIDTH-1:0] exp_k,
                           input logic [WIDTH-1:0] exp_q);
    issue(op, data, '0);
    chk({tag, "_drive_j"}, j_o, exp_j);
    chk({tag, "_drive_k"}, k_o, exp_k);
    chk({tag, "_drive_busy"}, busy_o, 1'b1);
    chk({tag, "_drive_ready"}, cmd_ready_o, 1'b0);
    chk({tag, "_drive_done"}, done_o, 1'b0);
    step();
    chk({tag, "_q"}, q_i, exp_q);
    chk({tag, "_done"}, done_o, 1'b1);
    chk({tag, "_check_jk"}, {j_o, k_o}, '0);
    step();
    chk({tag, "_done_clr"}, done_o, 1'b0);
    chk({tag, "_ready"}, cmd_ready_o, 1'b1);
    chk({tag, "_idle_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_jk", {j_o, k_o}, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_q", q_i, 4'b0000);
    step();
    step();
    rst_i = 1'b0;
    step();
    chk("rst_ready", cmd_ready_o, 1'b1);

    // LOAD 1010 from 0000
    single_op("load", 3'b100, 4'b1010, 4'b1010, 4'b0101, 4'b1010);
    chk("load_err", err_o, 1'b0);

    // TOG / SET / CLR leave unmasked bits alone
    single_op("tog", 3'b011, 4'b0011, 4'b0011, 4'b0011, 4'b1001);
    single_op("set", 3'b001, 4'b0100, 4'b0100, 4'b0000, 4'b1101);
    single_op("clr", 3'b010, 4'b1000, 4'b0000, 4'b1000, 4'b0101);

    // COUNT_UP wrap: 1110 -> 1111, 0000, 0001
    single_op("load_e", 3'b100, 4'b1110, 4'b1110, 4'b0001, 4'b1110);
    issue(3'b101, '0, 8'd3);
    chk("up_t0", j_o, 4'b0001);
    chk("up_busy0", busy_o, 1'b1);
    step();
    chk("up_q1", q_i, 4'b1111);
    chk("up_t1", k_o, 4'b1111);
    chk("up_done1", done_o, 1'b0);
    step();
    chk("up_q2", q_i, 4'b0000);
    chk("up_t2", j_o, 4'b0001);
    chk("up_busy2", busy_o, 1'b1);
    step();
    chk("up_q3", q_i, 4'b0001);
    chk("up_done3", done_o, 1'b1);
    chk("up_busy3", busy_o, 1'b1);
    chk("up_check_jk", {j_o, k_o}, '0);
    step();
    chk("up_done_clr", done_o, 1'b0);
    chk("up_idle", busy_o, 1'b0);
    chk("up_q_hold", q_i, 4'b0001);

    // COUNT_DOWN wrap: 0000 -> 1111, 1110
    single_op("load_0", 3'b100, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    issue(3'b110, '0, 8'd2);
    chk("dn_t0", j_o, 4'b1111);
    step();
    chk("dn_q1", q_i, 4'b1111);
    chk("dn_t1", k_o, 4'b0001);
    chk("dn_done1", done_o, 1'b0);
    step();
    chk("dn_q2", q_i, 4'b1110);
    chk("dn_done2", done_o, 1'b1);
    step();
    chk("dn_ready", cmd_ready_o, 1'b1);

    // Zero-length count: straight to completion, no J/K activity
    issue(3'b101, '0, 8'd0);
    chk("len0_done", done_o, 1'b1);
    chk("len0_jk", {j_o, k_o}, '0);
    step();
    chk("len0_q", q_i, 4'b1110);
    chk("len0_ready", cmd_ready_o, 1'b1);
    chk("len0_done_clr", done_o, 1'b0);

    // LOAD read-back mismatch: bank appears stuck at 0000
    force_zero = 1'b1;
    issue(3'b100, 4'b0110, '0);
    chk("mis_j", j_o, 4'b0110);
    chk("mis_k", k_o, 4'b1001);
    chk("mis_err_drive", err_o, 1'b0);
    step();
    chk("mis_done", done_o, 1'b1);
    chk("mis_err_check", err_o, 1'b1);
    step();
    chk("mis_err_idle", err_o, 1'b1);
    step();
    chk("mis_err_hold", err_o, 1'b1);
    force_zero = 1'b0;
    issue(3'b000, '0, '0);
    chk("nop_done", done_o, 1'b1);
    chk("nop_err_clr", err_o, 1'b0);
    chk("nop_jk", {j_o, k_o}, '0);
    step();
    chk("nop_ready", cmd_ready_o, 1'b1);

    // Reserved op
    issue(3'b111, 4'b1111, 8'd5);
    chk("rsv_err", err_o, 1'b1);
    chk("rsv_done", done_o, 1'b1);
    chk("rsv_jk", {j_o, k_o}, '0);
    step();
    chk("rsv_err_hold", err_o, 1'b1);
    chk("rsv_done_clr", done_o, 1'b0);
    chk("rsv_jk_idle", {j_o, k_o}, '0);
    chk("rsv_q", q_i, 4'b0110);

    // Reset mid-count; a different command held valid during RUN is ignored
    issue(3'b101, '0, 8'd10);
    cmd_valid_i = 1'b1;
    cmd_op_i    = 3'b100;
    cmd_data_i  = 4'b0000;
    chk("run_ready", cmd_ready_o, 1'b0);
    step();
    chk("run_q1", q_i, 4'b0111);
    step();
    chk("run_q2", q_i, 4'b1000);
    step();
    chk("run_q3", q_i, 4'b1001);
    chk("run_t3", j_o, 4'b0011);
    chk("run_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("arst_jk", {j_o, k_o}, '0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    chk("arst_q", q_i, 4'b0000);
    step();
    chk("arst_done2", done_o, 1'b0);
    cmd_valid_i = 1'b0;
    rst_i = 1'b0;
    step();
    chk("arst_ready", cmd_ready_o, 1'b1);
    chk("arst_idle", busy_o, 1'b0);
    chk("arst_err", err_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
